// File: rtl/mult_div_pkg.sv
// Shared encodings for the multiply/divide sequencer and the control unit.
// State codes and HI/LO source selects live here so both sides agree.
package mult_div_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MULT_INIT = 3'd1;
  localparam logic [2:0] S_MULT_RUN  = 3'd2;
  localparam logic [2:0] S_DIV_INIT  = 3'd3;
  localparam logic [2:0] S_DIV_RUN   = 3'd4;
  localparam logic [2:0] S_WRITE     = 3'd5;
  localparam logic [2:0] S_DIV0      = 3'd6;

  typedef enum logic [2:0] {
    IDLE      = S_IDLE,
    MULT_INIT = S_MULT_INIT,
    MULT_RUN  = S_MULT_RUN,
    DIV_INIT  = S_DIV_INIT,
    DIV_RUN   = S_DIV_RUN,
    WRITE     = S_WRITE,
    DIV0      = S_DIV0
  } state_t;

  localparam logic HILO_SRC_MULT = 1'b0;
  localparam logic HILO_SRC_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_sequencer_if.sv
// Request/strobe bundle between the control unit, the sequencer
// and the shared multiply/divide datapath.
interface mult_div_sequencer_if;

  logic mult_req;
  logic div_req;
  logic divisor_zero;
  logic mult_start;
  logic mult_step;
  logic div_start;
  logic div_step;
  logic last_step;
  logic hilo_src;
  logic hi_write;
  logic lo_write;
  logic busy;
  logic done;
  logic div_zero;

  modport master (
    output mult_req,
    output div_req,
    output divisor_zero,
    input  mult_start,
    input  mult_step,
    input  div_start,
    input  div_step,
    input  last_step,
    input  hilo_src,
    input  hi_write,
    input  lo_write,
    input  busy,
    input  done,
    input  div_zero
  );

  modport slave (
    input  mult_req,
    input  div_req,
    input  divisor_zero,
    output mult_start,
    output mult_step,
    output div_start,
    output div_step,
    output last_step,
    output hilo_src,
    output hi_write,
    output lo_write,
    output busy,
    output done,
    output div_zero
  );

endinterface

// File: rtl/iter_counter.sv
// Iteration counter for the mult/div sequencer.
// Holds when idle; flags the final iteration.
module iter_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == TERM);

endmodule

// File: rtl/mult_div_sequencer.sv
// Sequences the shared iterative multiplier/divider: load, WIDTH steps,
// HI/LO commit, plus an early divide-by-zero exit. All outputs are Moore.
module mult_div_sequencer
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic             clk,
  input logic             reset,
  mult_div_sequencer_if.slave bus
);

  state_t state;
  state_t state_nxt;
  logic   op_is_div;
  logic   op_nxt;
  logic   cnt_clr;
  logic   cnt_en;
  logic   term;

  iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .last  (term)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_is_div <= HILO_SRC_MULT;
    end else begin
      state     <= state_nxt;
      op_is_div <= op_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    op_nxt         = op_is_div;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;
    bus.mult_start = 1'b0;
    bus.mult_step  = 1'b0;
    bus.div_start  = 1'b0;
    bus.div_step   = 1'b0;
    bus.last_step  = 1'b0;
    bus.hi_write   = 1'b0;
    bus.lo_write   = 1'b0;
    bus.done       = 1'b0;
    bus.div_zero   = 1'b0;
    // Select stays on the last committed source until a new op loads.
    bus.hilo_src   = op_is_div;
    bus.busy       = (state != IDLE);

    unique case (state)
      IDLE: begin
        if (bus.mult_req) begin
          state_nxt = MULT_INIT;
          op_nxt    = HILO_SRC_MULT;
        end else if (bus.div_req && bus.divisor_zero) begin
          state_nxt = DIV0;
        end else if (bus.div_req) begin
          state_nxt = DIV_INIT;
          op_nxt    = HILO_SRC_DIV;
        end
      end
      MULT_INIT: begin
        bus.mult_start = 1'b1;
        cnt_clr        = 1'b1;
        state_nxt      = MULT_RUN;
      end
      MULT_RUN: begin
        bus.mult_step = 1'b1;
        bus.last_step = term;
        cnt_en        = 1'b1;
        if (term) state_nxt = WRITE;
      end
      DIV_INIT: begin
        bus.div_start = 1'b1;
        cnt_clr       = 1'b1;
        state_nxt     = DIV_RUN;
      end
      DIV_RUN: begin
        bus.div_step  = 1'b1;
        bus.last_step = term;
        cnt_en        = 1'b1;
        if (term) state_nxt = WRITE;
      end
      WRITE: begin
        bus.hi_write = 1'b1;
        bus.lo_write = 1'b1;
        bus.done     = 1'b1;
        state_nxt    = IDLE;
      end
      DIV0: begin
        bus.div_zero = 1'b1;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: a cycle-offset reference model
// predicts every output each cycle and the expected completion events.
module tb_mult_div_sequencer;

  localparam int W  = 32;
  localparam int CW = 6;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mult_div_sequencer_if bus ();

  mult_div_sequencer #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Model: one active op, identified by kind and the edge that accepted it.
  // kind 0 = mult, 1 = div, 2 = divide-by-zero
  int   ecnt      = 0;
  int   free_edge = 0;
  int   op_edge   = -1000;
  int   op_kind   = 0;
  logic act       = 1'b0;
  logic exp_hilo  = 1'b0;

  typedef struct {
    int kind;
    int at_edge;
  } resp_t;

  resp_t sb[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: edge %0d got %0h expected %0h", name, ecnt, got, exp);
  endtask

  function automatic void start_op(input int k);
    act     = 1'b1;
    op_kind = k;
    op_edge = ecnt;
    if (k == 2) begin
      free_edge = ecnt + 2;
      sb.push_back('{kind: 2, at_edge: ecnt});
    end else begin
      free_edge = ecnt + W + 3;
      exp_hilo  = (k == 1);
      sb.push_back('{kind: k, at_edge: ecnt + W + 1});
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      act       = 1'b0;
      exp_hilo  = 1'b0;
      free_edge = 0;
      sb.delete();
    end else begin
      ecnt++;
      if (ecnt >= free_edge) begin
        if (bus.mult_req) start_op(0);
        else if (bus.div_req && bus.divisor_zero) start_op(2);
        else if (bus.div_req) start_op(1);
      end
    end
  end

  // {mult_start,mult_step,div_start,div_step,last,hilo,hi,lo,busy,done,dz}
  function automatic logic [10:0] exp_vec();
    logic [10:0] v;
    int d;
    v    = '0;
    d    = ecnt - op_edge;
    v[5] = exp_hilo;
    if (act && op_kind == 2) begin
      if (d == 0) begin
        v[0] = 1'b1;
        v[2] = 1'b1;
      end
    end else if (act) begin
      if (d == 0) v[op_kind == 1 ? 8 : 10] = 1'b1;
      if (d >= 1 && d <= W) v[op_kind == 1 ? 7 : 9] = 1'b1;
      if (d == W) v[6] = 1'b1;
      if (d == W + 1) begin
        v[4] = 1'b1;
        v[3] = 1'b1;
        v[1] = 1'b1;
      end
      if (d >= 0 && d <= W + 1) v[2] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [10:0] obs();
    return {bus.mult_start, bus.mult_step, bus.div_start, bus.div_step,
            bus.last_step, bus.hilo_src, bus.hi_write, bus.lo_write,
            bus.busy, bus.done, bus.div_zero};
  endfunction

  always @(negedge clk) begin
    logic [10:0] ev;
    resp_t r;
    int k;
    ev = reset ? 11'd0 : exp_vec();
    chk("outputs", int'(obs()), int'(ev));
    if (!reset && (bus.done || bus.div_zero)) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL resp: unexpected completion at edge %0d", ecnt);
      end else begin
        r = sb.pop_front();
        k = bus.div_zero ? 2 : (bus.hilo_src ? 1 : 0);
        chk("resp_kind", k, r.kind);
        chk("resp_edge", ecnt, r.at_edge);
      end
    end
  end

  task automatic drive(input logic m, input logic d, input logic z);
    @(negedge clk);
    bus.mult_req     = m;
    bus.div_req      = d;
    bus.divisor_zero = z;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.mult_req     = 1'b0;
    bus.div_req      = 1'b0;
    bus.divisor_zero = 1'b0;
    #2 reset = 1'b1;
    #1 chk("async_reset", int'(obs()), 0);
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int r;
    bus.mult_req     = 1'b0;
    bus.div_req      = 1'b0;
    bus.divisor_zero = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    drive(1'b1, 1'b0, 1'b0);
    idle(W + 4);
    drive(1'b0, 1'b1, 1'b0);
    idle(W + 4);
    drive(1'b0, 1'b1, 1'b1);
    idle(4);

    drive(1'b1, 1'b1, 1'b0);
    idle(9);
    drive(1'b0, 1'b1, 1'b0);
    idle(24);
    drive(1'b0, 1'b1, 1'b0);
    idle(W + 4);

    drive(1'b1, 1'b0, 1'b0);
    idle(11);
    pulse_reset();
    drive(1'b1, 1'b0, 1'b0);
    idle(W + 4);

    repeat (3000) begin
      r = int'($urandom_range(0, 199));
      if (r < 2) pulse_reset();
      else drive(r < 12, r >= 8 && r < 20, $urandom_range(0, 2) == 0);
    end
    idle(W + 4);

    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
